// File: rtl/rr_arbiter_8_pkg.sv
// Shared types, constants and the rotating-priority search for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Rotate so that bit 'start' lands at position 0, take the lowest set bit,
    // then rotate the position back into absolute requester numbering.
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                      input logic [IDX_W-1:0] start);
        logic [2*N_REQ-1:0] doubled;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   pos;
        pick_t              res;
        doubled   = {req, req} >> start;
        rot       = doubled[N_REQ-1:0];
        pos       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) pos = IDX_W'(i);
        end
        res.found = |req;
        res.idx   = start + pos;
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
interface rr_arbiter_8_if;
    import rr_arbiter_8_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (output en, req, input gnt, gnt_idx, gnt_valid);
    modport slave  (input en, req, output gnt, gnt_idx, gnt_valid);

endinterface

// File: rtl/decoder_3x8_beh.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module decoder_3x8_beh (
    input  logic [2:0] a,
    input  logic       en,
    output logic [7:0] q
);

    always_comb begin
        q = '0;
        if (en) q[a] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a hold limit under contention;
// the registered winner index is decoded to a one-hot grant.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_8_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state,     state_nxt;
    logic [IDX_W-1:0] gnt_idx_q, idx_nxt;
    logic [IDX_W-1:0] ptr,       ptr_nxt;
    logic [CNT_W-1:0] hold_cnt,  cnt_nxt;

    logic [N_REQ-1:0] others;
    logic             keep;
    pick_t            pick_first;
    pick_t            pick_next;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // is only seen on a rising edge; no asynchronous sensitivity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx_q <= '0;
            ptr       <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            gnt_idx_q <= idx_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= cnt_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = gnt_idx_q;
        ptr_nxt    = ptr;
        cnt_nxt    = hold_cnt;

        others     = bus.req & ~(N_REQ'(1) << gnt_idx_q);
        keep       = bus.en && bus.req[gnt_idx_q] &&
                     ((hold_cnt < HOLD_LAST) || (others == '0));
        pick_first = rr_pick(bus.req, ptr);
        // The releasing winner is masked and the search starts just past it.
        pick_next  = rr_pick(others, gnt_idx_q + 3'd1);

        case (state)
            IDLE: begin
                if (bus.en && pick_first.found) begin
                    state_nxt = GRANT;
                    idx_nxt   = pick_first.idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (keep) begin
                    if (hold_cnt < HOLD_LAST) cnt_nxt = hold_cnt + 1'b1;
                end else begin
                    ptr_nxt = gnt_idx_q + 3'd1;
                    cnt_nxt = '0;
                    if (bus.en && pick_next.found) begin
                        idx_nxt = pick_next.idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt_valid = (state == GRANT);
        bus.gnt_idx   = gnt_idx_q;
    end

    decoder_3x8_beh u_dec (
        .a  (gnt_idx_q),
        .en (state == GRANT),
        .q  (bus.gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: behavioural scoreboard plus directed scenarios.
module tb_rr_arbiter_8;
    import rr_arbiter_8_pkg::*;

    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    rr_arbiter_8_if bus();

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb_q[$];

    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;
    int         m_cnt;

    function automatic logic [2:0] m_search(input logic [7:0] r, input logic [2:0] from);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (int'(from) + k) % 8;
            if (r[j]) return 3'(j);
        end
        return 3'd0;
    endfunction

    // Reference behaviour, advanced once per driven edge.
    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] oth;
        if (!r) begin
            m_valid = 1'b0; m_idx = '0; m_ptr = '0; m_cnt = 0;
        end else if (!m_valid) begin
            if (e && q != 8'h00) begin
                m_idx = m_search(q, m_ptr); m_valid = 1'b1; m_cnt = 0;
            end
        end else begin
            oth = q;
            oth[m_idx] = 1'b0;
            if (e && q[m_idx] && (m_cnt < MAX_HOLD - 1 || oth == 8'h00)) begin
                if (m_cnt < MAX_HOLD - 1) m_cnt++;
            end else begin
                m_ptr = m_idx + 3'd1;
                m_cnt = 0;
                if (e && oth != 8'h00) m_idx = m_search(oth, m_ptr);
                else m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle: inputs set at the falling edge, expectation queued,
    // return 2 time units after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic [7:0] q);
        exp_t x;
        @(negedge clk);
        rst_n   = r;
        bus.en  = e;
        bus.req = q;
        model_step(r, e, q);
        x.valid = m_valid;
        x.idx   = m_idx;
        x.gnt   = m_valid ? (8'h01 << m_idx) : 8'h00;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            n_cmp++;
            if (bus.gnt !== x.gnt || bus.gnt_idx !== x.idx || bus.gnt_valid !== x.valid) begin
                n_mis++;
                $display("FAIL scoreboard t=%0t gnt=%h idx=%0d valid=%b exp gnt=%h idx=%0d valid=%b",
                         $time, bus.gnt, bus.gnt_idx, bus.gnt_valid, x.gnt, x.idx, x.valid);
            end
        end
    end

    task automatic test_reset();
        cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b0, 1'b1, 8'hFF);
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
            n_mis++;
            $display("FAIL reset_state gnt=%h valid=%b idx=%0d exp 00/0/0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
        end
        cyc(1'b1, 1'b1, 8'hFF);
        n_cmp++;
        if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0) begin
            n_mis++;
            $display("FAIL reset_first_grant gnt=%h idx=%0d exp 01/0", bus.gnt, bus.gnt_idx);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] order[4];
        order = '{3'd2, 3'd5, 3'd7, 3'd2};
        cyc(1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 16; c++) begin
            cyc(1'b1, 1'b1, 8'b1010_0100);
            n_cmp++;
            if (bus.gnt !== (8'h01 << order[c / 4])) begin
                n_mis++;
                $display("FAIL rotation_c%0d gnt=%h exp=%h", c, bus.gnt, 8'h01 << order[c / 4]);
            end
        end
    endtask

    task automatic test_single();
        cyc(1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, 1'b1, 8'h10);
            n_cmp++;
            if (bus.gnt !== 8'h10) begin
                n_mis++;
                $display("FAIL single_c%0d gnt=%h exp=10", c, bus.gnt);
            end
        end
        cyc(1'b1, 1'b1, 8'h00);
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL single_drop gnt=%h valid=%b exp 00/0", bus.gnt, bus.gnt_valid);
        end
    endtask

    task automatic test_early_release();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h03);
        n_cmp++;
        if (bus.gnt !== 8'h01) begin
            n_mis++;
            $display("FAIL early_first gnt=%h exp=01", bus.gnt);
        end
        cyc(1'b1, 1'b1, 8'h02);
        n_cmp++;
        if (bus.gnt !== 8'h02) begin
            n_mis++;
            $display("FAIL early_switch gnt=%h exp=02", bus.gnt);
        end
    endtask

    task automatic test_enable();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h08);
        cyc(1'b1, 1'b1, 8'h08);
        cyc(1'b1, 1'b0, 8'h08);
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd3) begin
            n_mis++;
            $display("FAIL enable_off gnt=%h idx=%0d exp 00/3", bus.gnt, bus.gnt_idx);
        end
        cyc(1'b1, 1'b1, 8'h08);
        n_cmp++;
        if (bus.gnt !== 8'h08) begin
            n_mis++;
            $display("FAIL enable_back gnt=%h exp=08", bus.gnt);
        end
    endtask

    task automatic test_mid_reset();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h40);
        cyc(1'b1, 1'b1, 8'h40);
        cyc(1'b0, 1'b1, 8'h40);
        n_cmp++;
        if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset_clear gnt=%h valid=%b exp 00/0", bus.gnt, bus.gnt_valid);
        end
        cyc(1'b1, 1'b1, 8'hC1);
        n_cmp++;
        if (bus.gnt !== 8'h01) begin
            n_mis++;
            $display("FAIL midreset_next gnt=%h exp=01", bus.gnt);
        end
    endtask

    // Two requesters both held high: the releasing one is masked and the
    // grant alternates with no idle cycle.
    task automatic test_back_to_back();
        logic [7:0] exp_g;
        cyc(1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 12; c++) begin
            cyc(1'b1, 1'b1, 8'h03);
            exp_g = ((c / 4) % 2 == 0) ? 8'h01 : 8'h02;
            n_cmp++;
            if (bus.gnt !== exp_g) begin
                n_mis++;
                $display("FAIL b2b_c%0d gnt=%h exp=%h", c, bus.gnt, exp_g);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [7:0] rq;
            rq = 8'($urandom) & 8'($urandom);
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) != 0), rq);
            n_cmp++;
            if ($countones(bus.gnt) > 1) begin
                n_mis++;
                $display("FAIL random_onehot_c%0d gnt=%h exp at most one bit", c, bus.gnt);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        m_valid = 1'b0; m_idx = '0; m_ptr = '0; m_cnt = 0;
        test_reset();
        test_rotation();
        test_single();
        test_early_release();
        test_enable();
        test_mid_reset();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one resource among eight requesters and drives a one-hot grant vector. The 3-bit winner index is decoded to the one-hot grant by the existing 3-to-8 decoder, with `gnt_valid` as the decoder enable. The block sits between requesting masters and a shared resource, such as a bus, memory port or display slot. A programmable hold limit bounds how long one requester can keep the grant while others are waiting.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles for one requester while any other request is pending; legal range 1..15.
- `CNT_W`, default 4: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous reset, active-low, sampled on the rising edge of `clk`.
- `en`  in  1: arbiter enable; when low, the grant is withdrawn and no new grant is issued.
- `req`  in  8: request vector; bit i high means requester i wants the resource.
- `gnt`  out  8: one-hot grant, equal to decode(`gnt_idx`) gated by `gnt_valid`; all-zero when no grant.
- `gnt_idx`  out  3: encoded index of the current or last winner.
- `gnt_valid`  out  1: a grant is active.

## Operation
- Reset (`rst_n` low at an edge) forces: state IDLE, `gnt_valid`=0, `gnt_idx`=0, `gnt`=8'h00, `ptr`=0, `hold_cnt`=0. Reset overrides all other inputs.
- State machine:
  - IDLE: no grant.
  - GRANT: `gnt_valid`=1.
- IDLE -> GRANT when `en`=1 and `req`!=0.
  - Winner is the first set bit searching upward from `ptr`, wrapping 7 -> 0.
  - Winner is loaded into `gnt_idx`; `hold_cnt` is set to 0.
- GRANT keeps the same winner when all of the following hold:
  - `en`=1;
  - `req[gnt_idx]`=1;
  - either `hold_cnt` < MAX_HOLD-1, or no other `req` bit is set.
  - On a keep, `hold_cnt` increments and saturates at MAX_HOLD-1.
- GRANT releases the current winner on any of these conditions:
  - `req[gnt_idx]`=0;
  - hold limit reached with another request pending;
  - `en`=0.
- On release:
  - `ptr` <= `gnt_idx`+1 (mod 8).
  - If `en`=1 and some requester other than `gnt_idx` is requesting, the next winner is chosen from `req` with bit `gnt_idx` masked. The search starts at `gnt_idx`+1. Stay in GRANT with `hold_cnt`=0; there is no idle bubble.
  - Otherwise go to IDLE.
- `en`=0 in any state: next state is IDLE, `gnt_valid`=0, `ptr` is updated as on a release when leaving GRANT, and `gnt_idx` holds its value.
- Arbitration within one edge is fair: a requester that is continuously asserted is granted within 7 × MAX_HOLD + 7 cycles.

## Timing
- Latency: a `req` value sampled at edge k produces `gnt` valid right after edge k (one register stage). `gnt` is combinational from the registered `gnt_idx`/`gnt_valid`, so there is no extra cycle.
- Grant switch (A to B) occurs in a single edge. `gnt` is never all-zero between back-to-back grants and never has two bits set.
- When `req[gnt_idx]` drops at cycle k (sampled at edge k), `gnt` changes after edge k.
- Contended hold: a requester keeps the grant for exactly MAX_HOLD cycles, then loses it at the following edge.
- Uncontended hold: the grant is unbounded, and `hold_cnt` stays saturated.
- Reset taken mid-grant clears `gnt` after that edge and sets `ptr` to 0.
- Simultaneous release and a new request from the same requester: that requester is masked for the release edge and is eligible again from the next edge.

## Structure
- A shared header `arb_defs.vh` holds:
  - state encodings (IDLE=1'b0, GRANT=1'b1);
  - the requester count (8);
  - the index width (3).
- Sub-module: `decoder_3x8_beh` instance, with `.a(gnt_idx)`, `.en(gnt_valid)`, `.q(gnt)`.
- The rotating priority search is a combinational function or always block inside this module: rotate by `ptr`, find the first set bit, rotate back.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=8'hFF and `en`=1 -> `gnt`=8'h00, `gnt_valid`=0. After release, at the first edge: `gnt`=8'h01, `gnt_idx`=0.
- Rotation: `req`=8'b1010_0100 held constant, MAX_HOLD=4 -> grants 2, 5, 7, 2, each exactly 4 cycles, with no gaps.
- Single requester: `req`=8'h10 for 20 cycles -> `gnt`=8'h10 for all 20 cycles. When `req` drops, `gnt`=8'h00 after the next edge.
- Early release: `req`=8'h03; requester 0 drops after 1 cycle -> `gnt` goes 8'h01 for 1 cycle, then 8'h02 with no bubble.
- Enable: during a grant to requester 3, pulse `en`=0 for 1 cycle -> `gnt`=8'h00 for 1 cycle. With `req`=8'h08, `gnt` returns to 8'h08, since `ptr`=4 wraps around to 3.
- Mid-operation reset: `rst_n`=0 during a grant to requester 6 -> `gnt`=8'h00 next cycle. With `req`=8'hC1 after reset, the next winner is 0.
